// File: rtl/ysyx_25050147_idu_stage.sv
// Pipelined RV32I/RV32E decode stage: valid/ready in, single output register, valid/ready out.
// Optional M-extension decode enabled by defining YSYX_25050147_IDU_RV32M_EN.
module ysyx_25050147_idu_stage #(
    parameter int unsigned NR_REGS = 32,
    parameter int unsigned RA_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [31:0]     in_pc,
    output logic [RA_W-1:0] raddr1,
    output logic [RA_W-1:0] raddr2,
    input  logic [31:0]     rs1,
    input  logic [31:0]     rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_pc,
    output logic [4:0]      op_type,
    output logic [31:0]     op_src1,
    output logic [31:0]     op_src2,
    output logic [31:0]     store_data,
    output logic [RA_W-1:0] rd,
    output logic            rd_wen,
    output logic [3:0]      alu_op,
    output logic [2:0]      funct3,
    output logic [31:0]     branch_off,
    output logic            is_beq,
    output logic            illegal,
    output logic            is_mext
);

    typedef enum logic [4:0] {
        OP_EBREAK = 5'd0,
        OP_JUMP   = 5'd1,
        OP_ELSE   = 5'd2,
        OP_STORE  = 5'd4,
        OP_LOAD   = 5'd8,
        OP_BRANCH = 5'd16
    } op_type_e;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    localparam bit RV32E = (NR_REGS == 16);

    opcode_e     opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = opcode_e'(in_inst[6:0]);
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    assign raddr1 = in_inst[19:15];
    assign raddr2 = in_inst[24:20];

    op_type_e    d_type;
    logic [31:0] d_src1, d_src2;
    logic [3:0]  d_alu;
    logic        d_wr, d_bad, d_rd_wen;
    logic        use_rs1, use_rs2, use_rd;
`ifdef YSYX_25050147_IDU_RV32M_EN
    logic        d_mext;
`endif

    always_comb begin
        d_type  = OP_ELSE;
        d_src1  = '0;
        d_src2  = '0;
        d_alu   = '0;
        d_wr    = 1'b0;
        d_bad   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
`ifdef YSYX_25050147_IDU_RV32M_EN
        d_mext  = 1'b0;
`endif
        case (opcode)
            OPC_JAL: begin
                d_type = OP_JUMP; d_src1 = imm_j; d_src2 = in_pc;
                d_wr = 1'b1; use_rd = 1'b1;
            end
            OPC_JALR: begin
                d_type = OP_JUMP; d_src1 = rs1; d_src2 = imm_i;
                d_wr = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OPC_OPIMM: begin
                d_src1 = rs1; d_src2 = imm_i;
                d_alu  = {in_inst[30] & (f3 == 3'b101), f3};
                d_wr = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
                if (f3 == 3'b001 && f7 != 7'b0000000)
                    d_bad = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
                    d_bad = 1'b1;
            end
            OPC_AUIPC: begin
                d_src1 = imm_u; d_src2 = in_pc;
                d_wr = 1'b1; use_rd = 1'b1;
            end
            OPC_LUI: begin
                d_src1 = imm_u;
                d_wr = 1'b1; use_rd = 1'b1;
            end
            OPC_OP: begin
                d_src1 = rs1; d_src2 = rs2;
                d_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                    d_alu = {in_inst[30], f3};
`ifdef YSYX_25050147_IDU_RV32M_EN
                else if (f7 == 7'b0000001) begin
                    d_alu  = {1'b0, f3};
                    d_mext = 1'b1;
                end
`endif
                else
                    d_bad = 1'b1;
            end
            OPC_STORE: begin
                d_type = OP_STORE; d_src1 = rs1; d_src2 = imm_s;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                d_bad = (f3 > 3'b010);
            end
            OPC_LOAD: begin
                d_type = OP_LOAD; d_src1 = rs1; d_src2 = imm_i;
                d_wr = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
                d_bad = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            OPC_BRANCH: begin
                d_type = OP_BRANCH; d_src1 = rs1; d_src2 = rs2;
                d_alu  = {1'b0, f3};
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                d_bad = (f3 == 3'b010 || f3 == 3'b011);
            end
            OPC_SYSTEM: begin
                if (in_inst == 32'h0010_0073)
                    d_type = OP_EBREAK;
                else
                    d_bad = 1'b1;
            end
            default: d_bad = 1'b1;
        endcase

        // RV32E: only register fields the instruction actually reads/writes are range-checked
        if (RV32E && ((use_rs1 && in_inst[19]) || (use_rs2 && in_inst[24]) || (use_rd && in_inst[11])))
            d_bad = 1'b1;

        if (d_bad) begin
            d_type = OP_ELSE;
            d_src1 = '0;
            d_src2 = '0;
            d_alu  = '0;
`ifdef YSYX_25050147_IDU_RV32M_EN
            d_mext = 1'b0;
`endif
        end
        d_rd_wen = d_wr && !d_bad && (in_inst[11:7] != 5'd0);
    end

    op_type_e op_type_q;
    logic     accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign op_type  = op_type_q;
    assign is_beq   = op_type_q[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            op_type_q  <= OP_EBREAK;
            op_src1    <= '0;
            op_src2    <= '0;
            store_data <= '0;
            rd         <= '0;
            rd_wen     <= 1'b0;
            alu_op     <= '0;
            funct3     <= '0;
            branch_off <= '0;
            illegal    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_pc     <= in_pc;
            op_type_q  <= d_type;
            op_src1    <= d_src1;
            op_src2    <= d_src2;
            store_data <= rs2;
            rd         <= in_inst[11:7];
            rd_wen     <= d_rd_wen;
            alu_op     <= d_alu;
            funct3     <= f3;
            branch_off <= imm_b;
            illegal    <= d_bad;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef YSYX_25050147_IDU_RV32M_EN
    always_ff @(posedge clk) begin
        if (rst)
            is_mext <= 1'b0;
        else if (accept)
            is_mext <= d_mext;
    end
`else
    assign is_mext = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25050147_idu_stage.sv
// Scoreboard bench for ysyx_25050147_idu_stage: an RV32I instance checked in full and an
// RV32E instance on the same stimulus checked for illegal/rd_wen.
module tb_ysyx_25050147_idu_stage;

    logic        clk, rst, in_valid, flush, out_ready;
    logic [31:0] in_inst, in_pc, rs1, rs2;

    logic        in_ready, out_valid, rd_wen, is_beq, illegal, is_mext;
    logic [4:0]  raddr1, raddr2, rd, op_type;
    logic [31:0] out_pc, op_src1, op_src2, store_data, branch_off;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;

    logic        e_in_ready, e_out_valid, e_rd_wen, e_is_beq, e_illegal, e_is_mext;
    logic [4:0]  e_raddr1, e_raddr2, e_rd, e_op_type;
    logic [31:0] e_out_pc, e_op_src1, e_op_src2, e_store_data, e_branch_off;
    logic [3:0]  e_alu_op;
    logic [2:0]  e_funct3;

    ysyx_25050147_idu_stage #(.NR_REGS(32), .RA_W(5)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .raddr1(raddr1), .raddr2(raddr2),
        .rs1(rs1), .rs2(rs2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .op_type(op_type), .op_src1(op_src1), .op_src2(op_src2),
        .store_data(store_data), .rd(rd), .rd_wen(rd_wen), .alu_op(alu_op), .funct3(funct3),
        .branch_off(branch_off), .is_beq(is_beq), .illegal(illegal), .is_mext(is_mext)
    );

    ysyx_25050147_idu_stage #(.NR_REGS(16), .RA_W(5)) u_dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .raddr1(e_raddr1), .raddr2(e_raddr2),
        .rs1(rs1), .rs2(rs2), .flush(flush), .out_valid(e_out_valid), .out_ready(out_ready),
        .out_pc(e_out_pc), .op_type(e_op_type), .op_src1(e_op_src1), .op_src2(e_op_src2),
        .store_data(e_store_data), .rd(e_rd), .rd_wen(e_rd_wen), .alu_op(e_alu_op), .funct3(e_funct3),
        .branch_off(e_branch_off), .is_beq(e_is_beq), .illegal(e_illegal), .is_mext(e_is_mext)
    );

    logic [181:0] dut_bus, e_bus;
    assign dut_bus = {out_valid, out_pc, op_type, op_src1, op_src2, store_data, rd, rd_wen,
                      alu_op, funct3, branch_off, is_beq, illegal, is_mext};
    assign e_bus   = {e_out_valid, e_out_pc, e_op_type, e_op_src1, e_op_src2, e_store_data, e_rd, e_rd_wen,
                      e_alu_op, e_funct3, e_branch_off, e_is_beq, e_illegal, e_is_mext};

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  ty;
        logic [31:0] s1, s2, sd;
        logic [4:0]  rd;
        logic        wen;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [31:0] off;
        logic        ill, mext, e_ill;
        int          tag;
    } exp_t;

    exp_t sbq[$];
    exp_t cur_exp;
    int   checks = 0, failures = 0;
    bit   m_valid = 1'b0;
    bit   acc = 1'b0;
    int   vec_no = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic exp_t ex(input logic [4:0] ty, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [4:0] rdx, input logic wen, input logic [3:0] alu,
                                input logic [2:0] f3, input logic [31:0] off,
                                input logic ill, input logic mext, input logic e_ill);
        exp_t e;
        e.pc = '0; e.sd = '0; e.tag = 0;
        e.ty = ty; e.s1 = s1; e.s2 = s2; e.rd = rdx; e.wen = wen; e.alu = alu;
        e.f3 = f3; e.off = off; e.ill = ill; e.mext = mext; e.e_ill = e_ill;
        return e;
    endfunction

    function automatic logic [181:0] exp_bus(input exp_t e);
        return {1'b1, e.pc, e.ty, e.s1, e.s2, e.sd, e.rd, e.wen, e.alu, e.f3, e.off,
                (e.ty == 5'd16), e.ill, e.mext};
    endfunction

    // Input side: handshake model, scoreboard push, out_valid/in_ready checks.
    always @(negedge clk) begin
        bit exp_rdy;
        exp_rdy = !m_valid || out_ready;
        if (!rst) begin
            chk("in_ready", {191'd0, in_ready}, {191'd0, exp_rdy});
            chk("out_valid", {191'd0, out_valid}, {191'd0, m_valid});
        end
        acc = in_valid && exp_rdy && !flush && !rst;
        if (rst || flush) begin
            m_valid = 1'b0;
            sbq.delete();
        end else if (acc) begin
            sbq.push_back(cur_exp);
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    end

    // Output side: pop and compare whenever the DUT hands a bundle over.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_bundle got=%h exp=none", dut_bus);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("bundle[%0d]", e.tag), {10'd0, dut_bus}, {10'd0, exp_bus(e)});
                chk($sformatf("rv32e[%0d]", e.tag), {190'd0, e_illegal, e_rd_wen},
                    {190'd0, e.e_ill, e.wen & !e.e_ill});
            end
        end
    end

    task automatic set_in(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] d1,
                          input logic [31:0] d2, input exp_t e);
        vec_no++;
        e.pc = pc; e.sd = d2; e.tag = vec_no;
        cur_exp = e;
        in_inst = inst; in_pc = pc; rs1 = d1; rs2 = d2; in_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] d1,
                        input logic [31:0] d2, input exp_t e);
        logic [31:0] t;
        set_in(inst, pc, d1, d2, e);
        #1;
        t = inst;
        chk("raddr", {182'd0, raddr1, raddr2}, {182'd0, t[19:15], t[24:20]});
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            if (acc) break;
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL accept_timeout got=0 exp=1");
        end
        #1;
        in_valid = 1'b0;
    endtask

    logic [181:0] snap;

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_pc = '0; rs1 = '0; rs2 = '0;
        cur_exp = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {10'd0, dut_bus}, '0);
        chk("reset_state_e", {10'd0, e_bus}, '0);
        rst = 1'b0;

        // Streaming, out_ready held high
        send(32'h00500093, 32'h80000000, 32'h0, 32'h11111111, ex(2, 0, 5, 1, 1, 4'b0000, 3'b000, 32'h800, 0, 0, 0));
        send(32'h402081B3, 32'h80000004, 32'd9, 32'd4, ex(2, 9, 4, 3, 1, 4'b1000, 3'b000, 32'hC02, 0, 0, 0));
        send(32'hFFC12283, 32'h80000008, 32'h100, 32'hAAAA5555, ex(8, 32'h100, 32'hFFFFFFFC, 5, 1, 0, 3'b010, 32'hFFFFFFE4, 0, 0, 0));
        send(32'h00208463, 32'h8000000C, 32'd7, 32'd7, ex(16, 7, 7, 8, 0, 0, 3'b000, 32'h8, 0, 0, 0));
        send(32'h00100073, 32'h80000010, 32'h55, 32'h66, ex(0, 0, 0, 0, 0, 0, 3'b000, 32'h0, 0, 0, 0));
`ifdef YSYX_25050147_IDU_RV32M_EN
        send(32'h022081B3, 32'h80000014, 32'd6, 32'd7, ex(2, 6, 7, 3, 1, 0, 3'b000, 32'h822, 0, 1, 0));
`else
        send(32'h022081B3, 32'h80000014, 32'd6, 32'd7, ex(2, 0, 0, 3, 0, 0, 3'b000, 32'h822, 1, 0, 1));
`endif
        send(32'h000880B3, 32'h80000018, 32'h1234, 32'h0, ex(2, 32'h1234, 0, 1, 1, 0, 3'b000, 32'h800, 0, 0, 1));
        send(32'h00000000, 32'h8000001C, 32'd3, 32'd4, ex(2, 0, 0, 0, 0, 0, 3'b000, 32'h0, 1, 0, 1));
        send(32'h40109093, 32'h80000020, 32'd3, 32'd4, ex(2, 0, 0, 1, 0, 0, 3'b001, 32'hC00, 1, 0, 1));
        send(32'h4030D113, 32'h80000024, 32'hF0, 32'd4, ex(2, 32'hF0, 32'h403, 2, 1, 4'b1101, 3'b101, 32'h402, 0, 0, 0));
        send(32'h0020A423, 32'h80000028, 32'h200, 32'hDEADBEEF, ex(4, 32'h200, 8, 8, 0, 0, 3'b010, 32'h8, 0, 0, 0));
        send(32'h12345537, 32'h8000002C, 32'd1, 32'd2, ex(2, 32'h12345000, 0, 10, 1, 0, 3'b101, 32'h12A, 0, 0, 0));
        send(32'h00001817, 32'h80000030, 32'd1, 32'd2, ex(2, 32'h1000, 32'h80000030, 16, 1, 0, 3'b001, 32'h10, 0, 0, 1));
        send(32'h010000EF, 32'h80000034, 32'd1, 32'd2, ex(1, 32'd16, 32'h80000034, 1, 1, 0, 3'b000, 32'h800, 0, 0, 0));
        send(32'h00008067, 32'h80000038, 32'h80001000, 32'd2, ex(1, 32'h80001000, 0, 0, 0, 0, 3'b000, 32'h0, 0, 0, 0));
        send(32'h00000073, 32'h8000003C, 32'd1, 32'd2, ex(2, 0, 0, 0, 0, 0, 3'b000, 32'h0, 1, 0, 1));
        send(32'h0020A463, 32'h80000040, 32'd1, 32'd2, ex(2, 0, 0, 8, 0, 0, 3'b010, 32'h8, 1, 0, 1));
        send(32'h0000B283, 32'h80000044, 32'd1, 32'd2, ex(2, 0, 0, 5, 0, 0, 3'b011, 32'h804, 1, 0, 1));
        @(posedge clk); #1;

        // Backpressure: held bundle must not move; release hands over with no bubble
        out_ready = 1'b0;
        send(32'h00500093, 32'h90000000, 32'h0, 32'h3, ex(2, 0, 5, 1, 1, 4'b0000, 3'b000, 32'h800, 0, 0, 0));
        set_in(32'h402081B3, 32'h90000004, 32'd20, 32'd5, ex(2, 20, 5, 3, 1, 4'b1000, 3'b000, 32'hC02, 0, 0, 0));
        snap = dut_bus;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_in_ready", {191'd0, in_ready}, '0);
            chk("stall_hold", {10'd0, dut_bus}, {10'd0, snap});
        end
        out_ready = 1'b1;
        @(posedge clk);
        chk("no_bubble_accept", {191'd0, acc}, {191'd0, 1'b1});
        #1; in_valid = 1'b0;
        @(posedge clk); #1;

        // Flush with a held bundle and a pending input: both lost
        out_ready = 1'b0;
        send(32'h00208463, 32'hA0000000, 32'd1, 32'd1, ex(16, 1, 1, 8, 0, 0, 3'b000, 32'h8, 0, 0, 0));
        set_in(32'h12345537, 32'hA0000004, 32'd1, 32'd2, ex(2, 32'h12345000, 0, 10, 1, 0, 3'b101, 32'h12A, 0, 0, 0));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_kill", {191'd0, out_valid}, '0);
        out_ready = 1'b1;
        // Flush while empty and ready: the incoming instruction is dropped
        set_in(32'h00500093, 32'hA0000008, 32'd0, 32'd0, ex(2, 0, 5, 1, 1, 0, 3'b000, 32'h800, 0, 0, 0));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop", {191'd0, out_valid}, '0);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a stall
        out_ready = 1'b0;
        send(32'h4030D113, 32'hB0000000, 32'hF0, 32'd4, ex(2, 32'hF0, 32'h403, 2, 1, 4'b1101, 3'b101, 32'h402, 0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_stall", {10'd0, dut_bus}, '0);
        chk("rst_mid_stall_e", {10'd0, e_bus}, '0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 192'(sbq.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
